load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and data_memory bus bundle for the load/store unit
interface load_store_unit_if #(
  parameter int RIDX_W = 5
);
  logic              LSU_req_valid;
  logic              LSU_req_ready;
  logic              LSU_req_store;
  logic [31:0]       LSU_base;
  logic [15:0]       LSU_offset;
  logic [31:0]       LSU_store_data;
  logic [RIDX_W-1:0] LSU_rd_idx;
  logic [15:0]       Mem_addr;
  logic [31:0]       Mem_wr_data;
  logic              CNTRL_write_en;
  logic [31:0]       Mem_data;
  logic              LSU_rsp_valid;
  logic              LSU_rsp_ready;
  logic [31:0]       LSU_rsp_data;
  logic [RIDX_W-1:0] LSU_rsp_rd_idx;
  logic              LSU_rsp_err;
  logic              LSU_busy;

  modport slave (
    input  LSU_req_valid, LSU_req_store, LSU_base, LSU_offset, LSU_store_data, LSU_rd_idx,
    input  Mem_data, LSU_rsp_ready,
    output LSU_req_ready, Mem_addr, Mem_wr_data, CNTRL_write_en,
    output LSU_rsp_valid, LSU_rsp_data, LSU_rsp_rd_idx, LSU_rsp_err, LSU_busy
  );

  modport master (
    output LSU_req_valid, LSU_req_store, LSU_base, LSU_offset, LSU_store_data, LSU_rd_idx,
    output Mem_data, LSU_rsp_ready,
    input  LSU_req_ready, Mem_addr, Mem_wr_data, CNTRL_write_en,
    input  LSU_rsp_valid, LSU_rsp_data, LSU_rsp_rd_idx, LSU_rsp_err, LSU_busy
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit driving a 64K-word data_memory
module load_store_unit #(
  parameter int RD_LATENCY = 1,
  parameter int RIDX_W     = 5
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD_WAIT, RESP} state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t            state_q;
  logic              ready_q;
  logic              busy_q;
  logic              we_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [15:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rsp_data_q;
  logic [RIDX_W-1:0] tag_q;
  logic [1:0]        cnt_q;

  logic [31:0]       ea_d;
  logic              ea_err_d;

  assign ea_d     = lsu.LSU_base + {{16{lsu.LSU_offset[15]}}, lsu.LSU_offset};
  assign ea_err_d = |ea_d[31:16];

  // ready_q is registered so it first rises on the edge after reset release
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (lsu.LSU_req_valid && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            tag_q   <= lsu.LSU_rd_idx;
            if (ea_err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              addr_q  <= ea_d[15:0];
              wdata_q <= lsu.LSU_store_data;
              if (lsu.LSU_req_store) begin
                state_q <= STORE;
                we_q    <= 1'b1;
              end else begin
                state_q <= LOAD_WAIT;
                cnt_q   <= LAT;
              end
            end
          end
        end
        STORE: begin
          we_q        <= 1'b0;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
        LOAD_WAIT: begin
          if (cnt_q == 2'd1) begin
            cnt_q       <= '0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= lsu.Mem_data;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (lsu.LSU_rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu.LSU_req_ready  = ready_q;
  assign lsu.LSU_busy       = busy_q;
  assign lsu.Mem_addr       = addr_q;
  assign lsu.Mem_wr_data    = wdata_q;
  assign lsu.CNTRL_write_en = we_q;
  assign lsu.LSU_rsp_valid  = rsp_valid_q;
  assign lsu.LSU_rsp_err    = rsp_err_q;
  assign lsu.LSU_rsp_data   = rsp_data_q;
  assign lsu.LSU_rsp_rd_idx = tag_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized scoreboard bench for load_store_unit with a latency-accurate memory model
module tb_load_store_unit;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  load_store_unit_if #(.RIDX_W(5)) bus ();

  load_store_unit #(.RD_LATENCY(LAT), .RIDX_W(5)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .lsu      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [logic [15:0]];

  logic [31:0] dmem [0:65535];
  logic [31:0] rd_d1, rd_d2;
  int          hold_n     = 0;
  bit          keep_valid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // data_memory stand-in: read data appears LAT cycles after the address is registered
  always @(posedge CLOCK_50) begin
    if (bus.CNTRL_write_en) dmem[bus.Mem_addr] <= bus.Mem_wr_data;
    rd_d1 <= dmem[bus.Mem_addr];
    rd_d2 <= rd_d1;
  end
  assign bus.Mem_data = (LAT == 1) ? dmem[bus.Mem_addr] : (LAT == 2) ? rd_d1 : rd_d2;

  always @(posedge CLOCK_50) begin
    #1;
    if (hold_n > 0) begin
      bus.LSU_rsp_ready = 1'b0;
      if (bus.LSU_rsp_valid) hold_n--;
    end else begin
      bus.LSU_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;
  logic        prev_err;

  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.CNTRL_write_en) begin
        if (wr_q.size() == 0) begin
          timeout("unexpected_write");
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", bus.Mem_addr, w.addr);
          chk("wr_data", bus.Mem_wr_data, w.data);
        end
      end
      if (bus.LSU_rsp_valid) begin
        chk("ready_low_in_resp", bus.LSU_req_ready, 1'b0);
        if (prev_hold) begin
          chk("stable_data", bus.LSU_rsp_data, prev_data);
          chk("stable_idx", bus.LSU_rsp_rd_idx, prev_idx);
          chk("stable_err", bus.LSU_rsp_err, prev_err);
        end
        if (bus.LSU_rsp_ready) begin
          prev_hold = 1'b0;
          if (rsp_q.size() == 0) begin
            timeout("unexpected_rsp");
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("rsp_data", bus.LSU_rsp_data, r.data);
            chk("rsp_idx", bus.LSU_rsp_rd_idx, r.idx);
            chk("rsp_err", bus.LSU_rsp_err, r.err);
          end
        end else begin
          prev_hold = 1'b1;
          prev_data = bus.LSU_rsp_data;
          prev_idx  = bus.LSU_rsp_rd_idx;
          prev_err  = bus.LSU_rsp_err;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic issue(input logic st, input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wd, input logic [4:0] tag);
    logic [31:0] ea;
    logic        err;
    rsp_t        r;
    int          n;
    int          exp_lat;
    n = 0;
    @(negedge CLOCK_50);
    while (!bus.LSU_req_ready && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 50) begin
      timeout("req_ready_wait");
      return;
    end
    bus.LSU_req_valid  = 1'b1;
    bus.LSU_req_store  = st;
    bus.LSU_base       = base;
    bus.LSU_offset     = off;
    bus.LSU_store_data = wd;
    bus.LSU_rd_idx     = tag;
    ea  = base + {{16{off[15]}}, off};
    err = (ea > 32'h0000_FFFF);
    r.err = err;
    r.idx = tag;
    if (err || st) r.data = '0;
    else r.data = ref_mem.exists(ea[15:0]) ? ref_mem[ea[15:0]] : 32'h0;
    if (!err && st) begin
      wr_q.push_back('{ea[15:0], wd});
      ref_mem[ea[15:0]] = wd;
    end
    rsp_q.push_back(r);
    exp_lat = err ? 0 : (st ? 1 : LAT);
    @(posedge CLOCK_50);
    #1;
    bus.LSU_req_valid  = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
    bus.LSU_req_store  = 1'($urandom_range(0, 1));
    bus.LSU_base       = $urandom_range(0, 31);
    bus.LSU_offset     = 16'($urandom);
    bus.LSU_store_data = $urandom;
    bus.LSU_rd_idx     = 5'($urandom);
    n = 0;
    @(negedge CLOCK_50);
    while (!bus.LSU_rsp_valid && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("latency", n, exp_lat);
    while (!(bus.LSU_rsp_valid && bus.LSU_rsp_ready) && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 200) timeout("rsp_handshake");
    bus.LSU_req_valid = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    logic [15:0] saved_addr;
    for (int i = 0; i < 65536; i++) dmem[i] = 32'h0;
    bus.LSU_req_valid  = 1'b0;
    bus.LSU_req_store  = 1'b0;
    bus.LSU_base       = '0;
    bus.LSU_offset     = '0;
    bus.LSU_store_data = '0;
    bus.LSU_rd_idx     = '0;
    bus.LSU_rsp_ready  = 1'b0;

    #12;
    chk("rst_we", bus.CNTRL_write_en, 1'b0);
    chk("rst_rsp_valid", bus.LSU_rsp_valid, 1'b0);
    chk("rst_busy", bus.LSU_busy, 1'b0);
    chk("rst_ready", bus.LSU_req_ready, 1'b0);
    chk("rst_outs", {bus.Mem_addr, bus.LSU_rsp_rd_idx, bus.LSU_rsp_err},
        {16'h0, 5'h0, 1'b0});
    chk("rst_data", {bus.Mem_wr_data, bus.LSU_rsp_data}, 64'h0);
    #10;
    RESET_N = 1'b1;
    #1;
    chk("ready_before_edge", bus.LSU_req_ready, 1'b0);
    @(posedge CLOCK_50);
    #1;
    chk("ready_first_edge", bus.LSU_req_ready, 1'b1);

    issue(1'b1, 32'd4, 16'd0, 32'd20, 5'd3);
    issue(1'b0, 32'd4, 16'd0, 32'd0, 5'd9);
    issue(1'b1, 32'd6, 16'd0, 32'd5, 5'd1);
    issue(1'b1, 32'd7, 16'd0, 32'd1, 5'd2);
    issue(1'b0, 32'd8, 16'hFFFE, 32'd0, 5'd17);
    issue(1'b0, 32'd8, 16'hFFFF, 32'd0, 5'd18);

    saved_addr = bus.Mem_addr;
    issue(1'b0, 32'h0000_FFFF, 16'd1, 32'd0, 5'd21);
    chk("err_addr_hold", bus.Mem_addr, saved_addr);
    issue(1'b1, 32'h0000_FFFF, 16'd1, 32'hABCD, 5'd22);
    chk("err_store_addr_hold", bus.Mem_addr, saved_addr);

    keep_valid = 1;
    hold_n     = 6;
    issue(1'b0, 32'd6, 16'd0, 32'd0, 5'd11);
    keep_valid = 0;

    @(negedge CLOCK_50);
    while (!bus.LSU_req_ready) @(negedge CLOCK_50);
    bus.LSU_req_valid  = 1'b1;
    bus.LSU_req_store  = 1'b1;
    bus.LSU_base       = 32'h30;
    bus.LSU_offset     = 16'h0;
    bus.LSU_store_data = 32'hDEAD;
    bus.LSU_rd_idx     = 5'd7;
    wr_q.push_back('{16'h30, 32'hDEAD});
    @(posedge CLOCK_50);
    #1;
    bus.LSU_req_valid = 1'b0;
    @(negedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_async_we", bus.CNTRL_write_en, 1'b0);
    chk("rst_async_busy", bus.LSU_busy, 1'b0);
    chk("rst_async_rsp", bus.LSU_rsp_valid, 1'b0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #3;
    RESET_N = 1'b1;
    #1;
    chk("ready_before_edge2", bus.LSU_req_ready, 1'b0);
    @(posedge CLOCK_50);
    #1;
    chk("ready_first_edge2", bus.LSU_req_ready, 1'b1);
    chk("no_rsp_after_abort", bus.LSU_rsp_valid, 1'b0);
    issue(1'b0, 32'h30, 16'd0, 32'd0, 5'd4);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] b;
      logic [15:0] o;
      b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
      o = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32) - 16);
      issue(1'($urandom_range(0, 1)), b, o, $urandom, 5'($urandom));
    end

    repeat (4) @(posedge CLOCK_50);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
